// File: rtl/miner_job_loader_if.sv
// Job word stream between the host/DMA side (master) and the job loader (slave).
interface miner_job_loader_if;
    logic        S_Valid_I;
    logic [31:0] S_Data_I;
    logic        S_Last_I;
    logic        S_Ready_O;

    modport master (output S_Valid_I, output S_Data_I, output S_Last_I, input S_Ready_O);
    modport slave  (input S_Valid_I, input S_Data_I, input S_Last_I, output S_Ready_O);
endinterface

// File: rtl/miner_job_loader.sv
// Miner job loader: latches nonce words, pulses the update trigger, replays payload as write strobes.
// Optional macro MINER_JOB_BYTESWAP_EN byte-reverses every stream word before use.
module miner_job_loader #(
    parameter int ADDR_WIDTH  = 7,
    parameter int NONCE_WORDS = 6
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         Enable_I,
    input  logic [31:0]                  ChunkLength_I,
    miner_job_loader_if.slave            s_if,
    output logic                         UpdateTrigger_O,
    output logic                         Wr_O,
    output logic [31:0]                  Data_O,
    output logic [NONCE_WORDS-1:0][31:0] Nonce_O,
    output logic [31:0]                  ChunkLength_O,
    output logic                         Busy_O,
    output logic                         JobDone_O,
    output logic                         Err_O,
    output logic [1:0]                   ErrCode_O,
    input  logic                         ErrClr_I,
    output logic [31:0]                  JobCount_O
);
    localparam int          NCW     = $clog2(NONCE_WORDS);
    localparam logic [31:0] MAX_LEN = 32'(24 + 4 * (2 ** ADDR_WIDTH));
    localparam logic [1:0]  ERR_SHORT  = 2'd1;
    localparam logic [1:0]  ERR_LONG   = 2'd2;
    localparam logic [1:0]  ERR_BADLEN = 2'd3;

    typedef enum logic [2:0] {ST_IDLE, ST_NONCE, ST_TRIG, ST_PAYLOAD, ST_DRAIN} state_t;

    state_t                        r_state;
    logic                          r_live;
    logic                          r_trig;
    logic                          r_wr;
    logic                          r_done;
    logic                          r_err;
    logic [1:0]                    r_code;
    logic [31:0]                   r_data;
    logic [31:0]                   r_chunk;
    logic [31:0]                   r_pw;
    logic [31:0]                   r_jobcnt;
    logic [NCW-1:0]                r_ncnt;
    logic [ADDR_WIDTH:0]           r_wcnt;
    logic [NONCE_WORDS-1:0][31:0]  r_nonce;

    logic                w_ready;
    logic                w_beat;
    logic                w_last;
    logic                w_len_ok;
    logic [31:0]         w_word;
    logic [ADDR_WIDTH:0] w_wcnt_inc;

`ifdef MINER_JOB_BYTESWAP_EN
    assign w_word = {s_if.S_Data_I[7:0], s_if.S_Data_I[15:8],
                     s_if.S_Data_I[23:16], s_if.S_Data_I[31:24]};
`else
    assign w_word = s_if.S_Data_I;
`endif

    // r_live keeps ready low while reset is held, so every output reads 0 in reset.
    assign w_ready    = r_live & ((r_state == ST_IDLE) ? Enable_I : (r_state != ST_TRIG));
    assign w_beat     = s_if.S_Valid_I & w_ready;
    assign w_last     = s_if.S_Last_I;
    assign w_len_ok   = (ChunkLength_I >= 32'd28) && (ChunkLength_I <= MAX_LEN);
    assign w_wcnt_inc = r_wcnt + (ADDR_WIDTH+1)'(1);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= ST_IDLE;
            r_live   <= 1'b0;
            r_trig   <= 1'b0;
            r_wr     <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= '0;
            r_data   <= '0;
            r_chunk  <= '0;
            r_pw     <= '0;
            r_jobcnt <= '0;
            r_ncnt   <= '0;
            r_wcnt   <= '0;
            r_nonce  <= '0;
        end else begin
            r_live <= 1'b1;
            r_trig <= 1'b0;
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            // Clear first so an error raised in the same cycle overrides it.
            if (ErrClr_I) begin
                r_err  <= 1'b0;
                r_code <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_beat) begin
                        r_chunk <= ChunkLength_I;
                        r_pw    <= (ChunkLength_I - 32'd21) >> 2;
                        r_wcnt  <= '0;
                        if (w_len_ok) begin
                            r_nonce[0] <= w_word;
                            r_ncnt     <= NCW'(1);
                            r_state    <= ST_NONCE;
                        end else begin
                            r_err   <= 1'b1;
                            r_code  <= ERR_BADLEN;
                            r_state <= w_last ? ST_IDLE : ST_DRAIN;
                        end
                    end
                end
                ST_NONCE: begin
                    if (w_beat) begin
                        r_nonce[r_ncnt] <= w_word;
                        r_ncnt          <= r_ncnt + NCW'(1);
                        if (w_last) begin
                            r_err   <= 1'b1;
                            r_code  <= ERR_SHORT;
                            r_state <= ST_IDLE;
                        end else if (r_ncnt == NCW'(NONCE_WORDS - 1)) begin
                            r_trig  <= 1'b1;
                            r_state <= ST_TRIG;
                        end
                    end
                end
                ST_TRIG: begin
                    r_state <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (w_beat) begin
                        r_wr   <= 1'b1;
                        r_data <= w_word;
                        r_wcnt <= w_wcnt_inc;
                        if (32'(w_wcnt_inc) == r_pw) begin
                            if (w_last) begin
                                r_done   <= 1'b1;
                                r_jobcnt <= r_jobcnt + 32'd1;
                                r_state  <= ST_IDLE;
                            end else begin
                                r_err   <= 1'b1;
                                r_code  <= ERR_LONG;
                                r_state <= ST_DRAIN;
                            end
                        end else if (w_last) begin
                            r_err   <= 1'b1;
                            r_code  <= ERR_SHORT;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_beat && w_last) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_if.S_Ready_O = w_ready;
    assign UpdateTrigger_O = r_trig;
    assign Wr_O            = r_wr;
    assign Data_O          = r_data;
    assign Nonce_O         = r_nonce;
    assign ChunkLength_O   = r_chunk;
    assign Busy_O          = (r_state != ST_IDLE);
    assign JobDone_O       = r_done;
    assign Err_O           = r_err;
    assign ErrCode_O       = r_code;
    assign JobCount_O      = r_jobcnt;
endmodule

// File: tb/tb_miner_job_loader.sv
// Directed bench for miner_job_loader: nominal, backpressure, short/long/bad-length jobs, clear, reset.
module tb_miner_job_loader;
    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              Enable_I;
    logic [31:0]       ChunkLength_I;
    logic              UpdateTrigger_O;
    logic              Wr_O;
    logic [31:0]       Data_O;
    logic [5:0][31:0]  Nonce_O;
    logic [31:0]       ChunkLength_O;
    logic              Busy_O;
    logic              JobDone_O;
    logic              Err_O;
    logic [1:0]        ErrCode_O;
    logic              ErrClr_I;
    logic [31:0]       JobCount_O;

    miner_job_loader_if s_if ();

    miner_job_loader #(.ADDR_WIDTH(7), .NONCE_WORDS(6)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Enable_I(Enable_I), .ChunkLength_I(ChunkLength_I),
        .s_if(s_if.slave), .UpdateTrigger_O(UpdateTrigger_O), .Wr_O(Wr_O), .Data_O(Data_O),
        .Nonce_O(Nonce_O), .ChunkLength_O(ChunkLength_O), .Busy_O(Busy_O),
        .JobDone_O(JobDone_O), .Err_O(Err_O), .ErrCode_O(ErrCode_O), .ErrClr_I(ErrClr_I),
        .JobCount_O(JobCount_O)
    );

    always #5 Clk = ~Clk;

`ifdef MINER_JOB_BYTESWAP_EN
    localparam logic [31:0] EXP_N0 = 32'h44332211;
    localparam logic [31:0] EXP_D0 = 32'hDDCCBBAA;
`else
    localparam logic [31:0] EXP_N0 = 32'h11223344;
    localparam logic [31:0] EXP_D0 = 32'hAABBCCDD;
`endif

    int errors = 0;
    int checks = 0;

    // Monitor of DUT output pulses, sampled on the falling edge.
    int          cyc = 0;
    int          wr_n, wr_first, wr_last, trig_n, trig_cyc, done_n, overlap;
    logic [31:0] wr_d[$];
    int          beat_cyc, nonce6_cyc;
    logic        busy_after;

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (Wr_O) begin
            if (wr_n == 0) wr_first = cyc;
            wr_last = cyc;
            wr_d.push_back(Data_O);
            wr_n++;
        end
        if (UpdateTrigger_O) begin
            trig_n++;
            trig_cyc = cyc;
        end
        if (JobDone_O) done_n++;
        if (UpdateTrigger_O && Wr_O) overlap++;
    end

    function automatic logic [31:0] swap(input logic [31:0] w);
`ifdef MINER_JOB_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] nonce_w(input int j, input int k);
        return 32'h11223344 + 32'(j * 32'h100) + 32'(k);
    endfunction

    function automatic logic [31:0] pay_w(input int j, input int i);
        return 32'hAABBCCDD + 32'(j * 32'h00100000) + 32'((i - 1) * 32'h00010203);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        wr_n = 0; trig_n = 0; done_n = 0; overlap = 0;
        wr_first = 0; wr_last = 0; trig_cyc = 0;
        wr_d.delete();
    endtask

    task automatic idle();
        s_if.S_Valid_I = 1'b0;
        s_if.S_Last_I  = 1'b0;
    endtask

    // Present one word and hold it until the loader accepts it (bounded).
    task automatic send(input logic [31:0] w, input bit last, input bit gap);
        bit acc;
        int guard;
        if (gap) begin
            idle();
            @(posedge Clk); #1;
        end
        s_if.S_Valid_I = 1'b1;
        s_if.S_Data_I  = w;
        s_if.S_Last_I  = last;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
            @(negedge Clk);
            acc = s_if.S_Ready_O;
            @(posedge Clk); #1;
            guard++;
        end
        beat_cyc = cyc - 1;
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic run_job(input int j, input logic [31:0] len, input int nnon, input bit nlast,
                           input int npay, input bit gap, input bit drop_en);
        ChunkLength_I = len;
        mon_clear();
        for (int k = 0; k < nnon; k++) begin
            send(nonce_w(j, k), nlast && (k == nnon - 1), gap);
            if (k == 5) nonce6_cyc = beat_cyc;
            if (drop_en && k == 0) Enable_I = 1'b0;
        end
        for (int i = 1; i <= npay; i++) send(pay_w(j, i), i == npay, gap);
        busy_after = Busy_O;
        idle();
        repeat (3) @(posedge Clk);
        #1;
        Enable_I = 1'b1;
    endtask

    task automatic chk_data(input string tag, input int j, input int n);
        logic [31:0] got;
        chk({tag, "_wr_count"}, 64'(wr_n), 64'(n));
        for (int i = 0; i < n; i++) begin
            got = (i < wr_d.size()) ? wr_d[i] : 32'hxxxxxxxx;
            chk({tag, "_data"}, 64'(got), 64'(swap(pay_w(j, i + 1))));
        end
    endtask

    initial begin
        Rst_n = 1'b0; Enable_I = 1'b0; ChunkLength_I = '0; ErrClr_I = 1'b0;
        s_if.S_Data_I = '0;
        idle();
        mon_clear();
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_ready", 64'(s_if.S_Ready_O), 64'd0);
        chk("rst_busy", 64'(Busy_O), 64'd0);
        chk("rst_err", {62'd0, ErrCode_O}, 64'd0);
        chk("rst_jobcount", 64'(JobCount_O), 64'd0);
        chk("rst_nonce0", 64'(Nonce_O[0]), 64'd0);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        Enable_I = 1'b1;

        // 1. nominal job, 66 payload words
        run_job(0, 32'd286, 6, 1'b0, 66, 1'b0, 1'b0);
        chk("t1_nonce0", 64'(Nonce_O[0]), 64'(EXP_N0));
        chk("t1_nonce5", 64'(Nonce_O[5]), 64'(swap(nonce_w(0, 5))));
        chk("t1_chunklen", 64'(ChunkLength_O), 64'd286);
        chk("t1_trig_count", 64'(trig_n), 64'd1);
        chk("t1_trig_lat", 64'(trig_cyc - nonce6_cyc), 64'd1);
        chk("t1_first_wr_lat", 64'(wr_first - trig_cyc), 64'd2);
        chk("t1_first_data", 64'(wr_d.size() > 0 ? wr_d[0] : 32'hxxxxxxxx), 64'(EXP_D0));
        chk_data("t1", 0, 66);
        chk("t1_done", 64'(done_n), 64'd1);
        chk("t1_jobcount", 64'(JobCount_O), 64'd1);
        chk("t1_err", 64'(Err_O), 64'd0);
        chk("t1_overlap", 64'(overlap), 64'd0);
        chk("t1_busy_end", 64'(busy_after), 64'd0);
        chk("t1_data_hold", 64'(Data_O), 64'(swap(pay_w(0, 66))));

        // 2. same job, stream gaps every other cycle, Enable dropped mid-job
        run_job(1, 32'd286, 6, 1'b0, 66, 1'b1, 1'b1);
        chk_data("t2", 1, 66);
        chk("t2_span", 64'(wr_last - wr_first), 64'd130);
        chk("t2_done", 64'(done_n), 64'd1);
        chk("t2_jobcount", 64'(JobCount_O), 64'd2);
        chk("t2_err", 64'(Err_O), 64'd0);

        // 3. short job: last on payload word 40
        run_job(2, 32'd286, 6, 1'b0, 40, 1'b0, 1'b0);
        chk_data("t3", 2, 40);
        chk("t3_err", {61'd0, Err_O, ErrCode_O}, {61'd0, 1'b1, 2'd1});
        chk("t3_done", 64'(done_n), 64'd0);
        chk("t3_busy_next", 64'(busy_after), 64'd0);
        chk("t3_jobcount", 64'(JobCount_O), 64'd2);

        // 4. long job: PW 4, 8 words sent, then error clear
        run_job(3, 32'd40, 6, 1'b0, 8, 1'b0, 1'b0);
        chk_data("t4", 3, 4);
        chk("t4_err", {61'd0, Err_O, ErrCode_O}, {61'd0, 1'b1, 2'd2});
        chk("t4_busy_end", 64'(busy_after), 64'd0);
        chk("t4_done", 64'(done_n), 64'd0);
        ErrClr_I = 1'b1;
        @(posedge Clk); #1;
        ErrClr_I = 1'b0;
        chk("t4_clr", {61'd0, Err_O, ErrCode_O}, 64'd0);

        // last during nonce words
        run_job(4, 32'd286, 3, 1'b1, 0, 1'b0, 1'b0);
        chk("tn_err", {61'd0, Err_O, ErrCode_O}, {61'd0, 1'b1, 2'd1});
        chk("tn_trig", 64'(trig_n), 64'd0);
        chk("tn_busy", 64'(Busy_O), 64'd0);
        ErrClr_I = 1'b1;
        @(posedge Clk); #1;
        ErrClr_I = 1'b0;

        // 5. bad length, error raised while clear is held
        ChunkLength_I = 32'd20;
        mon_clear();
        ErrClr_I = 1'b1;
        send(32'h01010101, 1'b0, 1'b0);
        ErrClr_I = 1'b0;
        send(32'h02020202, 1'b0, 1'b0);
        send(32'h03030303, 1'b1, 1'b0);
        busy_after = Busy_O;
        idle();
        repeat (3) @(posedge Clk);
        #1;
        chk("t5_err", {61'd0, Err_O, ErrCode_O}, {61'd0, 1'b1, 2'd3});
        chk("t5_trig", 64'(trig_n), 64'd0);
        chk("t5_wr", 64'(wr_n), 64'd0);
        chk("t5_chunklen", 64'(ChunkLength_O), 64'd20);
        chk("t5_busy_end", 64'(busy_after), 64'd0);

        // reset in the middle of a nominal job's payload
        ChunkLength_I = 32'd286;
        mon_clear();
        for (int k = 0; k < 6; k++) send(nonce_w(5, k), 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) send(pay_w(5, i), 1'b0, 1'b0);
        idle();
        Rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(Busy_O), 64'd0);
        chk("rst_mid_wr", 64'(Wr_O), 64'd0);
        chk("rst_mid_nonce", 64'(Nonce_O[3]), 64'd0);
        chk("rst_mid_chunklen", 64'(ChunkLength_O), 64'd0);
        chk("rst_mid_jobcount", 64'(JobCount_O), 64'd0);
        chk("rst_mid_err", {61'd0, Err_O, ErrCode_O}, 64'd0);
        chk("rst_mid_ready", 64'(s_if.S_Ready_O), 64'd0);
        chk("rst_mid_data", 64'(Data_O), 64'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("post_rst_busy", 64'(Busy_O), 64'd0);
        chk("post_rst_ready", 64'(s_if.S_Ready_O), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
